fifo_frame_reader: RTL
======================

// Module: fifo_frame_reader
// PURPOSE
//  Read-side consumer for the async FIFO: pops words via rdreq/rdempty/q (show-ahead q) in the rdclk domain.
//  Wraps them into fixed-length frames (header, sequence, payload[, checksum]) on a valid/ready stream
//  towards the host-interface writer. Stalls on backpressure; pads a stalled frame after an empty-FIFO timeout.
// PARAMETERS
//  DATA_WIDTH     8      FIFO/stream word width
//  FRAME_LEN      16     payload words per frame (>=1)
//  HEADER_WORD    8'hA5  first word of every frame
//  PAD_WORD       8'h00  payload filler after timeout
//  TIMEOUT_CYCLES 255    consecutive starved payload cycles before padding (>=1)
// PORTS
//  rdclk         in   1           clock (shared with FIFO read port)
//  clear         in   1           synchronous active-high reset
//  q             in   DATA_WIDTH  FIFO head word, valid while rdempty=0
//  rdempty       in   1           FIFO empty
//  rdreq         out  1           pop FIFO head this cycle (combinational)
//  out_data      out  DATA_WIDTH  stream word
//  out_valid     out  1           out_data valid
//  out_ready     in   1           downstream accepts when out_valid&out_ready
//  out_sof       out  1           qualifies header word
//  out_eof       out  1           qualifies last word of frame
//  busy          out  1           state != IDLE
//  padded_frames out  16          frames completed with padding, saturating
// BEHAVIOUR
//  Single clock rdclk; clear is synchronous, active-high, highest priority.
//  Reset: out_valid=0, out_data=0, out_sof=0, out_eof=0, busy=0, padded_frames=0, seq=0, state=IDLE.
//  Output reg loads when ld = !out_valid | out_ready; held stable while out_valid&!out_ready.
//  FSM: IDLE -> HDR -> SEQ -> PAY -> [CSUM] -> IDLE.
//   IDLE: if !rdempty & ld -> load HEADER_WORD, out_sof=1, go SEQ (header valid 1 cycle after rdempty falls).
//   SEQ: on ld load seq, go PAY; pay_cnt=0, tmo=0, pad=0.
//   PAY: on ld: if !pad & !rdempty -> load q, rdreq=1, tmo=0; if pad -> load PAD_WORD, no rdreq;
//        else (starved) load nothing, out_valid drops, tmo++; tmo==TIMEOUT_CYCLES-1 sets pad next cycle.
//        Word index FRAME_LEN-1 loaded -> out_eof=1 (no CSUM) or go CSUM.
//   CSUM: on ld load checksum, out_eof=1, go IDLE.
//  rdreq = state==PAY & ld & !pad & !rdempty; never asserted when rdempty=1 or outside PAY.
//  Exactly one pop per payload word accepted into output reg; no pops on header/seq/csum/pad words.
//  seq: DATA_WIDTH bits, increments at eof transfer, wraps 2^DATA_WIDTH-1 -> 0.
//  pad sticky to end of frame; padded_frames++ at eof of a padded frame, saturates at 16'hFFFF.
//  Back-to-back: eof transfer and next header load may occur on consecutive cycles.
//  clear mid-frame: partial frame dropped (no eof emitted), out_valid=0 next cycle, FIFO untouched.
// CONFIGURATION
//  FRAME_CHECKSUM_EN defined: CSUM state present; trailer = (seq + sum of payload words incl. pad)
//   mod 2^DATA_WIDTH; frame = FRAME_LEN+3 words, eof on trailer.
//  Not defined: no CSUM state; frame = FRAME_LEN+2 words, eof on last payload word.
// TESTING
//  1 FIFO preloaded 16 words 0x01..0x10, out_ready=1 -> A5,00,01..10[,checksum 0x88]; 16 rdreq pulses; eof on last.
//  2 Same data, out_ready toggles 1/0 -> identical stream, out_data stable while stalled, no rdreq while out_ready=0.
//  3 FIFO holds 4 words then empty, TIMEOUT_CYCLES=8 -> 4 data, 8 idle cycles, 12 x 00, eof; padded_frames=1.
//  4 FIFO holds 16 words, clear after 3rd payload word -> out_valid=0 next cycle, busy=0; refill gives seq=00 frame.
//  5 257 full frames -> seq wraps FF->00; rdreq count = 257*16; padded_frames=0.
//  6 rdempty=1 always -> out_valid=0, rdreq=0, busy=0 forever.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops a show-ahead FIFO and wraps the words into fixed-length frames on a
// valid/ready stream. Define FRAME_CHECKSUM_EN to append a checksum trailer word to every frame.
module fifo_frame_reader #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    FRAME_LEN      = 16,
  parameter logic [DATA_WIDTH-1:0] HEADER_WORD    = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD       = 8'h00,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  rdclk,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] q,
  input  logic                  rdempty,
  output logic                  rdreq,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  busy,
  output logic [15:0]           padded_frames
);

  localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Each state names the word that will be loaded into the output register next.
  typedef enum logic [1:0] {
    IDLE,
    SEQ,
    PAY
`ifdef FRAME_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   seq;
  logic [CNT_W-1:0]        pay_cnt;
  logic [TMO_W-1:0]        tmo;
  logic                    pad;
`ifdef FRAME_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum;
`endif

  logic                    ld;
  logic                    load;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    load_sof;
  logic                    load_eof;
  logic                    seq_load;
  logic                    word_load;
  logic                    starve;
  logic                    eof_xfer;

  assign ld       = !out_valid || out_ready;
  assign eof_xfer = out_valid && out_ready && out_eof;
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    rdreq      = 1'b0;
    load       = 1'b0;
    load_data  = out_data;
    load_sof   = 1'b0;
    load_eof   = 1'b0;
    seq_load   = 1'b0;
    word_load  = 1'b0;
    starve     = 1'b0;
    case (state)
      IDLE: begin
        if (ld && !rdempty) begin
          load       = 1'b1;
          load_data  = HEADER_WORD;
          load_sof   = 1'b1;
          state_next = SEQ;
        end
      end
      SEQ: begin
        if (ld) begin
          load       = 1'b1;
          load_data  = seq;
          seq_load   = 1'b1;
          state_next = PAY;
        end
      end
      PAY: begin
        if (ld) begin
          if (pad) begin
            load      = 1'b1;
            load_data = PAD_WORD;
            word_load = 1'b1;
          end else if (!rdempty) begin
            load      = 1'b1;
            load_data = q;
            word_load = 1'b1;
            rdreq     = !clear;
          end else begin
            starve = 1'b1;
          end
          if (word_load && pay_cnt == LAST_IDX) begin
`ifdef FRAME_CHECKSUM_EN
            state_next = CSUM;
`else
            load_eof   = 1'b1;
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CSUM: begin
        if (ld) begin
          load       = 1'b1;
          load_data  = csum;
          load_eof   = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rdclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (clear) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_sof       <= 1'b0;
      out_eof       <= 1'b0;
      seq           <= '0;
      pay_cnt       <= '0;
      tmo           <= '0;
      pad           <= 1'b0;
      padded_frames <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      state <= state_next;

      // A starved load slot empties the output register rather than repeating a word.
      if (ld) begin
        out_valid <= load;
        out_sof   <= load_sof;
        out_eof   <= load_eof;
        if (load) out_data <= load_data;
      end

      if (seq_load) begin
        pay_cnt <= '0;
        tmo     <= '0;
        pad     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum    <= seq;
`endif
      end

      if (word_load) begin
        pay_cnt <= pay_cnt + 1'b1;
        tmo     <= '0;
`ifdef FRAME_CHECKSUM_EN
        csum    <= csum + load_data;
`endif
      end

      if (starve) begin
        tmo <= tmo + 1'b1;
        if (tmo == TMO_LAST) pad <= 1'b1;
      end

      // pad is still set here: the next frame's seq word cannot load before its header leaves.
      if (eof_xfer) begin
        seq <= seq + 1'b1;
        if (pad && padded_frames != 16'hFFFF) padded_frames <= padded_frames + 1'b1;
      end
    end
  end

endmodule
